// File: rtl/alu_op_sequencer.sv
// Command-to-ALU sequencer: latches a command, pulses the active-low operand
// register loads, waits for the ALU to settle, then holds the result until consumed.
module alu_op_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_op_a_i,
  input  logic [WIDTH-1:0] cmd_op_b_i,
  input  logic [1:0]       cmd_ctrl_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  output logic             en_reg_a_o,
  output logic             en_reg_b_o,
  output logic [1:0]       cntrl_alu_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_carry_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             busy_o,
  output logic [7:0]       txn_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_settle;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [1:0]       r_ctrl;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic [7:0]       r_txn_count;

  logic w_in_idle;
  logic w_in_load;
  logic w_in_resp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_settle     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_ctrl       <= '0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_txn_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op_a  <= cmd_op_a_i;
            r_op_b  <= cmd_op_b_i;
            r_ctrl  <= cmd_ctrl_i;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_settle <= SETTLE_INIT;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          // Result is sampled on the edge the countdown reaches zero.
          if (r_settle == '0) begin
            r_rsp_result <= alu_result_i;
            r_rsp_carry  <= alu_carry_i;
            r_state      <= S_RESP;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_txn_count <= r_txn_count + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so reset forces enables high.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_load = (r_state == S_LOAD);
  assign w_in_resp = (r_state == S_RESP);

  assign cmd_ready_o  = w_in_idle;
  assign busy_o       = ~w_in_idle;
  assign en_reg_a_o   = ~w_in_load;
  assign en_reg_b_o   = ~w_in_load;
  assign rsp_valid_o  = w_in_resp;
  assign op_a_o       = r_op_a;
  assign op_b_o       = r_op_b;
  assign cntrl_alu_o  = r_ctrl;
  assign rsp_result_o = r_rsp_result;
  assign rsp_carry_o  = r_rsp_carry;
  assign txn_count_o  = r_txn_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3) share one command
// stream and are compared every cycle against a cycle-age reference model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid;
  logic       rsp_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_ctrl;
  logic       ovr;
  logic [3:0] rnd_res;
  logic       rnd_car;

  logic [1:0]      w_ready, w_busy, w_ena, w_enb, w_rv, w_car, w_alu_car;
  logic [1:0][3:0] w_opa, w_opb, w_res, w_alu_res;
  logic [1:0][1:0] w_ctl;
  logic [1:0][7:0] w_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Bench ALU: 00 add (carry out), 01 sub (borrow), 10 and, 11 xor.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
    case (c)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {logic'(a < b), 4'(a - b)};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always_comb begin
    w_alu_res = '0;
    w_alu_car = '0;
    for (int d = 0; d < 2; d++) begin
      if (ovr) {w_alu_car[d], w_alu_res[d]} = {rnd_car, rnd_res};
      else     {w_alu_car[d], w_alu_res[d]} = alu(w_opa[d], w_opb[d], w_ctl[d]);
    end
  end

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(w_ready[0]),
    .cmd_op_a_i(cmd_a), .cmd_op_b_i(cmd_b), .cmd_ctrl_i(cmd_ctrl),
    .op_a_o(w_opa[0]), .op_b_o(w_opb[0]), .en_reg_a_o(w_ena[0]), .en_reg_b_o(w_enb[0]),
    .cntrl_alu_o(w_ctl[0]), .alu_result_i(w_alu_res[0]), .alu_carry_i(w_alu_car[0]),
    .rsp_valid_o(w_rv[0]), .rsp_ready_i(rsp_ready), .rsp_result_o(w_res[0]),
    .rsp_carry_o(w_car[0]), .busy_o(w_busy[0]), .txn_count_o(w_cnt[0]));

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(w_ready[1]),
    .cmd_op_a_i(cmd_a), .cmd_op_b_i(cmd_b), .cmd_ctrl_i(cmd_ctrl),
    .op_a_o(w_opa[1]), .op_b_o(w_opb[1]), .en_reg_a_o(w_ena[1]), .en_reg_b_o(w_enb[1]),
    .cntrl_alu_o(w_ctl[1]), .alu_result_i(w_alu_res[1]), .alu_carry_i(w_alu_car[1]),
    .rsp_valid_o(w_rv[1]), .rsp_ready_i(rsp_ready), .rsp_result_o(w_res[1]),
    .rsp_carry_o(w_car[1]), .busy_o(w_busy[1]), .txn_count_o(w_cnt[1]));

  // Reference model: age -1 = idle, 0 = load cycle, 1..S = settling, S+1 = responding.
  int         settle[2] = '{1, 3};
  int         m_age[2];
  logic [3:0] m_a[2], m_b[2], m_res[2];
  logic [1:0] m_c[2];
  logic       m_car[2];
  logic [7:0] m_cnt[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_age[d] = -1; m_a[d] = '0; m_b[d] = '0; m_c[d] = '0;
      m_res[d] = '0; m_car[d] = 1'b0; m_cnt[d] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_age[d] < 0) begin
        if (cmd_valid) begin
          m_age[d] = 0; m_a[d] = cmd_a; m_b[d] = cmd_b; m_c[d] = cmd_ctrl;
        end
      end else if (m_age[d] == settle[d]) begin
        m_age[d] = settle[d] + 1;
        {m_car[d], m_res[d]} = alu(m_a[d], m_b[d], m_c[d]);
      end else if (m_age[d] == settle[d] + 1) begin
        if (rsp_ready) begin
          m_age[d] = -1; m_cnt[d] = m_cnt[d] + 8'd1;
        end
      end else begin
        m_age[d] = m_age[d] + 1;
      end
    end
  endtask

  function automatic logic [27:0] act_vec(input int d);
    return {w_ready[d], w_busy[d], w_ena[d], w_enb[d], w_rv[d], w_opa[d], w_opb[d],
            w_ctl[d], w_res[d], w_car[d], w_cnt[d]};
  endfunction

  function automatic logic [27:0] exp_vec(input int d);
    logic idle, load;
    idle = (m_age[d] < 0);
    load = (m_age[d] == 0);
    return {idle, ~idle, ~load, ~load, logic'(m_age[d] == settle[d] + 1), m_a[d], m_b[d],
            m_c[d], m_res[d], m_car[d], m_cnt[d]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("state_s1", 32'(act_vec(0)), 32'(exp_vec(0)));
    check("state_s3", 32'(act_vec(1)), 32'(exp_vec(1)));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_model();
    check("rst_en_a", 32'(w_ena), 32'h3);
    check("rst_en_b", 32'(w_enb), 32'h3);
    check("rst_rsp_valid", 32'(w_rv), 32'h0);
    check("rst_busy", 32'(w_busy), 32'h0);
    check("rst_count", 32'(w_cnt), 32'h0);
    #1;
    rst = 1'b0;
  endtask

  // One full transaction on both instances, checking latency and captured result.
  task automatic run_vec(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c,
                         input logic [3:0] er, input logic ec);
    int lat[2];
    lat = '{0, 0};
    cmd_a = a; cmd_b = b; cmd_ctrl = c; cmd_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("load_en", 32'({w_ena, w_enb}), 32'h0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) check("exec_en", 32'({w_ena, w_enb}), 32'hF);
      for (int d = 0; d < 2; d++) if (lat[d] == 0 && w_rv[d]) lat[d] = n;
      if (lat[0] != 0 && lat[1] != 0) break;
    end
    check("latency_s1", 32'(lat[0]), 32'd2);
    check("latency_s3", 32'(lat[1]), 32'd4);
    check("result", 32'({w_res[1], w_res[0]}), 32'({er, er}));
    check("carry", 32'(w_car), 32'({ec, ec}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("done_idle", 32'(w_busy), 32'h0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
    logic [3:0] res;
    logic       car;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [4:0] rc;
    logic [3:0] held;
    logic [7:0] c0;
    int nresp;
    logic pre;

    tbl[0] = '{4'h9, 4'h8, 2'd0, 4'h1, 1'b1};
    tbl[1] = '{4'h3, 4'h2, 2'd0, 4'h5, 1'b0};
    tbl[2] = '{4'h5, 4'h7, 2'd1, 4'hE, 1'b1};
    tbl[3] = '{4'h7, 4'h3, 2'd1, 4'h4, 1'b0};
    tbl[4] = '{4'hC, 4'hA, 2'd2, 4'h8, 1'b0};
    tbl[5] = '{4'hF, 4'h5, 2'd3, 4'hA, 1'b0};
    tbl[6] = '{4'hF, 4'h1, 2'd0, 4'h0, 1'b1};
    tbl[7] = '{4'h0, 4'h0, 2'd3, 4'h0, 1'b0};

    cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_a = '0; cmd_b = '0; cmd_ctrl = '0;
    ovr = 1'b0; rnd_res = '0; rnd_car = 1'b0;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].res, tbl[i].car);
      check("txn_count", 32'(w_cnt[0]), 32'(i + 1));
    end

    // Backpressure with a wandering ALU result and a competing command.
    cmd_a = 4'h6; cmd_b = 4'h4; cmd_ctrl = 2'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int n = 0; n < 20 && w_rv != 2'b11; n++) tick();
    check("bp_valid", 32'(w_rv), 32'h3);
    held = w_res[0];
    check("bp_result", 32'(held), 32'hA);
    ovr = 1'b1; cmd_valid = 1'b1; cmd_a = 4'h1; cmd_b = 4'h1;
    for (int n = 0; n < 10; n++) begin
      rnd_res = 4'($urandom); rnd_car = 1'($urandom);
      tick();
      check("bp_hold", 32'({w_res[1], w_res[0]}), 32'({held, held}));
      check("bp_ready", 32'(w_ready), 32'h0);
    end
    ovr = 1'b0; cmd_valid = 1'b0;
    check("bp_no_latch", 32'(w_opa[0]), 32'h6);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-to-back: valid and ready held high; three responses from the settle-1 instance.
    c0 = w_cnt[0]; nresp = 0;
    cmd_a = 4'h2; cmd_b = 4'h3; cmd_ctrl = 2'd0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int n = 0; n < 40 && nresp < 3; n++) begin
      pre = w_rv[0];
      tick();
      if (pre) begin
        nresp++;
        check("b2b_idle_gap", 32'({w_ready[0], w_busy[0]}), 32'h2);
      end
    end
    cmd_valid = 1'b0;
    check("b2b_count", 32'(w_cnt[0] - c0), 32'd3);
    for (int n = 0; n < 10 && w_busy != 2'b00; n++) tick();
    rsp_ready = 1'b0;
    check("b2b_drain", 32'(w_busy), 32'h0);

    // Reset while both instances are settling.
    do_reset();
    cmd_a = 4'h4; cmd_b = 4'h4; cmd_ctrl = 2'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_exec", 32'({w_busy, w_rv}), 32'hC);
    do_reset();
    tick();
    check("post_rst_count", 32'(w_cnt), 32'h0);
    run_vec(4'h9, 4'h8, 2'd0, 4'h1, 1'b1);
    check("post_rst_txn", 32'(w_cnt[0]), 32'd1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cmd_valid = 1'($urandom); rsp_ready = 1'($urandom);
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_ctrl = 2'($urandom);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int n = 0; n < 10 && w_busy != 2'b00; n++) tick();
    rsp_ready = 1'b0;
    check("rand_drain", 32'(w_busy), 32'h0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_ctrl = 2'($urandom);
      rc = alu(cmd_a, cmd_b, cmd_ctrl);
      run_vec(cmd_a, cmd_b, cmd_ctrl, rc[3:0], rc[4]);
    end
    check("wrap_256", 32'(w_cnt), 32'h0);
    run_vec(4'h3, 4'h2, 2'd0, 4'h5, 1'b0);
    check("wrap_257", 32'(w_cnt), 32'h0101);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width.
REQ-002 Parameter SETTLE_CYCLES, default 1, range 1..15, ALU settle cycles after operand load.
REQ-003 clk_i  input  1  sole clock; one clock, all state rising-edge.
REQ-004 rst_i  input  1  reset; reset is asynchronous and active-high.
REQ-005 cmd_valid_i  input  1  command request.
REQ-006 cmd_ready_o  output  1  sequencer can accept a command.
REQ-007 cmd_op_a_i  input  WIDTH  operand A.
REQ-008 cmd_op_b_i  input  WIDTH  operand B.
REQ-009 cmd_ctrl_i  input  2  ALU control code, passed through unmodified.
REQ-010 op_a_o  output  WIDTH  operand A to datapath.
REQ-011 op_b_o  output  WIDTH  operand B to datapath.
REQ-012 en_reg_a_o  output  1  active-low load enable, operand A register.
REQ-013 en_reg_b_o  output  1  active-low load enable, operand B register.
REQ-014 cntrl_alu_o  output  2  ALU control to datapath.
REQ-015 alu_result_i  input  WIDTH  datapath result.
REQ-016 alu_carry_i  input  1  datapath carry.
REQ-017 rsp_valid_o  output  1  response available.
REQ-018 rsp_ready_i  input  1  consumer accepts response.
REQ-019 rsp_result_o  output  WIDTH  captured result.
REQ-020 rsp_carry_o  output  1  captured carry.
REQ-021 busy_o  output  1  high in any state other than IDLE.
REQ-022 txn_count_o  output  8  completed transactions, modulo 256.

Function
REQ-023 FSM states IDLE, LOAD, EXEC, RESP; every output registered or decoded from state/registers only, no input-to-output combinational path.
REQ-024 IDLE: cmd_ready_o=1; cmd_valid_i high at an edge latches op A, op B, ctrl into op_a_o, op_b_o, cntrl_alu_o and moves to LOAD.
REQ-025 LOAD (exactly 1 cycle): en_reg_a_o=en_reg_b_o=0; next edge moves to EXEC with settle counter loaded with SETTLE_CYCLES-1.
REQ-026 EXEC: both enables 1; counter decrements each edge; at the edge where counter is 0, alu_result_i/alu_carry_i captured into rsp_result_o/rsp_carry_o, move to RESP.
REQ-027 RESP: rsp_valid_o=1; edge with rsp_ready_i=1 moves to IDLE and increments txn_count_o (255 wraps to 0).
REQ-028 Latency: rsp_valid_o rises on the (SETTLE_CYCLES+1)-th rising edge after the accepting edge when rsp side idle.
REQ-029 cmd_ready_o=0 in LOAD, EXEC, RESP; cmd_valid_i in those states ignored, no latch.
REQ-030 op_a_o, op_b_o, cntrl_alu_o stable from accepting edge until next accept; not cleared on return to IDLE.
REQ-031 rsp_result_o, rsp_carry_o stable while rsp_valid_o=1 regardless of alu inputs; retain value after handshake.
REQ-032 rsp_ready_i outside RESP has no effect.
REQ-033 Back-to-back: minimum one IDLE cycle between response handshake and next accept; cmd held valid through RESP is accepted at the first edge in IDLE.
REQ-034 All four cmd_ctrl_i codes legal; no decode or error path.

Reset
REQ-035 rst_i assertion immediately (asynchronously) forces IDLE, cmd_ready_o=1 after release, busy_o=0, en_reg_a_o=en_reg_b_o=1, op_a_o=op_b_o=0, cntrl_alu_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_carry_o=0, txn_count_o=0.
REQ-036 Reset mid-transaction (any of LOAD/EXEC/RESP) aborts it: no response emitted, count not incremented; first edge after release is IDLE behaviour.
REQ-037 Enables never glitch low on reset release.

Verification
REQ-038 WIDTH=4, SETTLE=1, bench ALU model ctrl 00 = add: cmd A=4'h9, B=4'h8 -> one LOAD cycle with both enables 0, rsp_valid 2 edges after accept, rsp_result=4'h1, rsp_carry=1, txn_count=1.
REQ-039 SETTLE=3: cmd A=4'h3, B=4'h2 -> rsp_valid 4 edges after accept, result 4'h5, carry 0.
REQ-040 Backpressure: hold rsp_ready_i=0 for 10 cycles while driving alu_result_i randomly -> rsp_result_o unchanged, cmd_ready_o=0, second cmd_valid not latched.
REQ-041 Back-to-back: cmd_valid held high for 3 commands, rsp_ready_i=1 -> three responses, one IDLE cycle between each, txn_count=3.
REQ-042 Assert rst_i during EXEC -> same cycle en high, rsp_valid 0, busy 0; txn_count stays 0; next command completes normally.
REQ-043 Issue 256 transactions -> txn_count_o wraps to 0, then 1 after the 257th.
